aes_stream_packer: RTL and testbench
====================================

Name: aes_stream_packer

Overview:
- Engine front/back end between the HWPE streamer and the AES round core.
- Packs the 32-bit plaintext stream into 128-bit blocks and hands each block to the round core over a valid/ready handshake.
- Unpacks each 128-bit ciphertext result back into a 32-bit sink stream.
- Driven by the engine control (clear/start/enable) from the HWPE FSM; reports busy/done and a block count.

Parameters:
- WORD_W, 32, stream word width in bits.
- BLOCK_W, 128, AES block width in bits; must equal 4*WORD_W.
- CNT_W, 16, width of the block-count registers.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous soft clear; returns the block to IDLE
- enable  in  1  0 freezes state, counters and buffers
- start  in  1  one-cycle job start; sampled only in IDLE
- nblocks_i  in  CNT_W  number of 128-bit blocks in the job; latched on start
- in_data_i  in  WORD_W  plaintext word from the streamer source
- in_valid_i  in  1  plaintext word valid
- in_ready_o  out  1  plaintext word ready
- blk_data_o  out  BLOCK_W  packed block to the round core
- blk_valid_o  out  1  block valid
- blk_ready_i  in  1  round core accepts the block
- res_data_i  in  BLOCK_W  ciphertext block from the round core
- res_valid_i  in  1  result valid
- res_ready_o  out  1  result ready
- out_data_o  out  WORD_W  ciphertext word to the streamer sink
- out_valid_o  out  1  ciphertext word valid
- out_ready_i  in  1  sink ready
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle job-complete pulse
- blk_cnt_o  out  CNT_W  number of blocks completed in the current job

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; word index, blk_cnt and nblocks register = 0; data buffers = 0.
  - All valid/ready outputs, busy_o and done_o = 0.
- clear: synchronous; same effect as reset and takes priority over enable and start. Any partially packed block is discarded.
- Handshake: a transfer occurs when valid & ready are both high on a rising edge. Once a valid output is raised, it and its data stay stable until the transfer completes.
- Byte order: the first word in maps to bits [127:96], the fourth word to [31:0]. Drain order is the same: [127:96] goes out first.
- IDLE:
  - On start, latch nblocks_i and reset blk_cnt to 0.
  - If nblocks_i == 0, go to DONE; otherwise go to FILL.
- FILL:
  - in_ready_o = 1.
  - Each accepted word is written to its slot and the 2-bit word index increments.
  - On acceptance of the 4th word the index wraps to 0 and the state goes to ISSUE.
- ISSUE: blk_valid_o = 1. On blk_ready_i, go to WAIT.
- WAIT:
  - res_ready_o = 1.
  - On res_valid_i, capture res_data_i into the output buffer and go to DRAIN.
  - A res_valid_i outside WAIT is ignored (not captured).
- DRAIN:
  - out_valid_o = 1; out_data_o = buffer slot selected by the word index.
  - On the 4th accepted word, blk_cnt increments.
  - If the incremented count == nblocks, go to DONE; otherwise go to FILL.
- DONE: done_o = 1 for exactly one cycle, then go to IDLE. blk_cnt_o holds its value until the next start or clear.
- start outside IDLE is ignored.
- enable = 0:
  - in_ready_o and res_ready_o are forced to 0; no state, index or counter changes.
  - blk_valid_o and out_valid_o already asserted stay asserted with stable data, but a transfer completes only when enable = 1.
  - done_o is not emitted until enable returns.
- Throughput with zero back-pressure: 4 fill + 1 issue + 1 wait + 4 drain = 10 cycles per block.
- Blocks are not overlapped: the next FILL begins only after DRAIN finishes.
- The block counter wraps modulo 2^CNT_W. nblocks = 2^CNT_W - 1 is the maximum job size.

Test Plan:
- Single block: start with nblocks=1, words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, core returns 0x69C4E0D86A7B0430D8CDB78070B4C55A with zero wait.
  - blk_data_o = 0x00112233445566778899AABBCCDDEEFF.
  - Output words come out 0x69C4E0D8 first.
  - done_o pulses exactly 10 cycles after the first word is accepted; blk_cnt_o = 1.
- Back-pressure: hold blk_ready_i low 3 cycles, then toggle out_ready_i 1/0.
  - Data stays stable while stalled; no words are lost or duplicated.
  - Output order is unchanged.
- Zero-length job: nblocks=0 with start.
  - DONE one cycle later; done_o pulses; in_ready_o never rises; blk_cnt_o = 0.
- Enable freeze: drop enable after the 2nd word for 5 cycles while in_valid_i stays high.
  - No words are accepted during the freeze.
  - After resume, the 3rd and 4th words fill slots [63:32] and [31:0].
- Clear mid-job: assert clear during DRAIN of block 2 of a 3-block job.
  - Next cycle: IDLE, all outputs 0, blk_cnt_o = 0.
  - A fresh start then runs normally.
- Multi-block: nblocks=3 with random valid/ready jitter on all ports.
  - 12 words in and 12 words out, matching a scoreboard.
  - blk_cnt_o steps 1, 2, 3; a single done_o pulse; start asserted mid-job is ignored.

Source files
------------

// File: rtl/aes_stream_packer.sv
// ---------------------------------------------------------------------------
// aes_stream_packer
//
// Front/back end between the HWPE streamer and the AES round core. Gathers
// four WORD_W plaintext words into one BLOCK_W block, hands it to the round
// core, waits for the ciphertext block and drains it back out as four words.
// Blocks are processed strictly one at a time.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   clear, enable, start  engine control (soft clear, freeze, job start)
//   nblocks_i             number of blocks in the job, latched on start
//   in_*                  plaintext word stream (valid/ready sink side)
//   blk_*                 packed block to the round core (valid/ready source)
//   res_*                 ciphertext block from the round core (valid/ready sink)
//   out_*                 ciphertext word stream (valid/ready source side)
//   busy_o, done_o        status: not idle / one-cycle job-complete pulse
//   blk_cnt_o             blocks completed in the current job
//
// BLOCK_W must equal 4*WORD_W; the word index is a fixed 2-bit counter.
// Word 0 of a block lives in the most significant slot on both sides.
// ---------------------------------------------------------------------------
module aes_stream_packer #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic               start,
    input  logic [CNT_W-1:0]   nblocks_i,
    input  logic [WORD_W-1:0]  in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [BLOCK_W-1:0] blk_data_o,
    output logic               blk_valid_o,
    input  logic               blk_ready_i,
    input  logic [BLOCK_W-1:0] res_data_i,
    input  logic               res_valid_i,
    output logic               res_ready_o,
    output logic [WORD_W-1:0]  out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   blk_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [CNT_W-1:0]   nblocks_q, nblocks_d;
    logic [BLOCK_W-1:0] in_buf_q, in_buf_d;
    logic [BLOCK_W-1:0] out_buf_q, out_buf_d;
    logic [CNT_W-1:0]   cnt_inc;

    // Status and handshake outputs decode straight from the state register.
    // The ready outputs and done are gated by enable so a frozen engine
    // neither accepts data nor reports completion; the valid outputs are not
    // gated, so an offered block/word stays offered across a freeze.
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE)  && enable;
    assign in_ready_o  = (state_q == S_FILL)  && enable;
    assign res_ready_o = (state_q == S_WAIT)  && enable;
    assign blk_valid_o = (state_q == S_ISSUE);
    assign out_valid_o = (state_q == S_DRAIN);
    assign blk_data_o  = in_buf_q;
    assign blk_cnt_o   = blk_cnt_q;
    assign cnt_inc     = blk_cnt_q + CNT_W'(1);

    // Drain mux: word index 0 selects the most significant slot.
    always_comb begin
        out_data_o = '0;
        for (int i = 0; i < 4; i++) begin
            if (idx_q == 2'(i)) begin
                out_data_o = out_buf_q[BLOCK_W - WORD_W*(i+1) +: WORD_W];
            end
        end
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first, so paths that do not
        // assign a signal hold it instead of inferring a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        blk_cnt_d = blk_cnt_q;
        nblocks_d = nblocks_q;
        in_buf_d  = in_buf_q;
        out_buf_d = out_buf_q;

        if (clear) begin
            state_d   = S_IDLE;
            idx_d     = '0;
            blk_cnt_d = '0;
            nblocks_d = '0;
            in_buf_d  = '0;
            out_buf_d = '0;
        end else if (enable) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        nblocks_d = nblocks_i;
                        blk_cnt_d = '0;
                        idx_d     = '0;
                        state_d   = (nblocks_i == '0) ? S_DONE : S_FILL;
                    end
                end
                S_FILL: begin
                    if (in_valid_i) begin
                        for (int i = 0; i < 4; i++) begin
                            if (idx_q == 2'(i)) begin
                                in_buf_d[BLOCK_W - WORD_W*(i+1) +: WORD_W] = in_data_i;
                            end
                        end
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (blk_ready_i) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (res_valid_i) begin
                        out_buf_d = res_data_i;
                        state_d   = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_ready_i) begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            blk_cnt_d = cnt_inc;
                            state_d   = (cnt_inc == nblocks_q) ? S_DONE : S_FILL;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: the block buffers are ordinary registers, not RAM, so they take
    // the asynchronous reset and come up as all-zero along with the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            blk_cnt_q <= '0;
            nblocks_q <= '0;
            in_buf_q  <= '0;
            out_buf_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            idx_q     <= idx_d;
            blk_cnt_q <= blk_cnt_d;
            nblocks_q <= nblocks_d;
            in_buf_q  <= in_buf_d;
            out_buf_q <= out_buf_d;
        end
    end

endmodule

// File: tb/tb_aes_stream_packer.sv
// ---------------------------------------------------------------------------
// tb_aes_stream_packer
//
// Directed bench for aes_stream_packer. A common job driver (run_job) plays
// source, round core and sink, and records what crossed each interface; one
// task per scenario then compares the record with hand-computed values.
// ---------------------------------------------------------------------------
module tb_aes_stream_packer;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 128;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear;
    logic               enable;
    logic               start;
    logic [CNT_W-1:0]   nblocks_i;
    logic [WORD_W-1:0]  in_data_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [BLOCK_W-1:0] blk_data_o;
    logic               blk_valid_o;
    logic               blk_ready_i;
    logic [BLOCK_W-1:0] res_data_i;
    logic               res_valid_i;
    logic               res_ready_o;
    logic [WORD_W-1:0]  out_data_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic               busy_o;
    logic               done_o;
    logic [CNT_W-1:0]   blk_cnt_o;

    always #5 clk = ~clk;

    aes_stream_packer #(
        .WORD_W (WORD_W),
        .BLOCK_W(BLOCK_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .enable     (enable),
        .start      (start),
        .nblocks_i  (nblocks_i),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .blk_data_o (blk_data_o),
        .blk_valid_o(blk_valid_o),
        .blk_ready_i(blk_ready_i),
        .res_data_i (res_data_i),
        .res_valid_i(res_valid_i),
        .res_ready_o(res_ready_o),
        .out_data_o (out_data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .blk_cnt_o  (blk_cnt_o)
    );

    int errors = 0;
    int checks = 0;

    logic [WORD_W-1:0]  words   [12];
    logic [BLOCK_W-1:0] results [3];

    // Record of one job, filled by run_job.
    logic [BLOCK_W-1:0] blk_seen [$];
    logic [WORD_W-1:0]  out_seen [$];
    logic [CNT_W-1:0]   cnt_steps[$];
    int                 done_cnt;
    int                 done_t;
    int                 first_acc;
    int                 stable_err;
    int                 in_ready_seen;
    int                 frozen_fires;
    logic [CNT_W-1:0]   cnt_at_done;

    function automatic logic [BLOCK_W-1:0] exp_blk(input int b);
        return {words[4*b], words[4*b+1], words[4*b+2], words[4*b+3]};
    endfunction

    function automatic logic [WORD_W-1:0] exp_word(input int n);
        logic [BLOCK_W-1:0] r;
        r = results[n/4];
        return r[WORD_W*(3 - n%4) +: WORD_W];
    endfunction

    task automatic idle_inputs();
        start       = 1'b0;
        clear       = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        blk_ready_i = 1'b0;
        res_valid_i = 1'b0;
        res_data_i  = '0;
        out_ready_i = 1'b0;
    endtask

    // Drives one job. Inputs change at the falling edge, outputs are sampled
    // 1 ns later, transfers happen on the following rising edge.
    task automatic run_job(input int nb, input bit jitter, input int blk_stall,
                           input bit out_toggle, input bit freeze,
                           input bit midstart, input int clear_blk);
        int in_idx = 0, res_idx = 0, stall = 0, frz = 0, post = 0, t = 0;
        bit fin = 0, hold_blk = 0, hold_out = 0;
        bit inf, blkf, resf, outf;
        logic [BLOCK_W-1:0] prev_blk = '0;
        logic [WORD_W-1:0]  prev_out = '0;
        logic [CNT_W-1:0]   last_cnt;
        blk_seen.delete(); out_seen.delete(); cnt_steps.delete();
        done_cnt = 0; done_t = -1; first_acc = -1; stable_err = 0;
        in_ready_seen = 0; frozen_fires = 0; cnt_at_done = '0;
        @(negedge clk);
        idle_inputs();
        enable    = 1'b1;
        start     = 1'b1;
        nblocks_i = nb[CNT_W-1:0];
        last_cnt  = blk_cnt_o;
        @(posedge clk);
        while (!fin) begin
            @(negedge clk);
            start  = 1'b0;
            enable = 1'b1;
            if (midstart && in_idx == 5) begin start = 1'b1; nblocks_i = 16'd7; end
            if (freeze && in_idx == 2 && frz < 5) begin enable = 1'b0; frz++; end
            in_valid_i  = (in_idx < 4*nb) && (jitter ? ($urandom_range(0, 1) == 1) : 1'b1);
            in_data_i   = (in_idx < 4*nb) ? words[in_idx] : '0;
            res_valid_i = (res_idx < nb) && (jitter ? ($urandom_range(0, 1) == 1) : 1'b1);
            res_data_i  = (res_idx < nb) ? results[res_idx] : '0;
            blk_ready_i = (stall >= blk_stall) && (jitter ? ($urandom_range(0, 1) == 1) : 1'b1);
            out_ready_i = out_toggle ? (t % 2 == 0) : (jitter ? ($urandom_range(0, 1) == 1) : 1'b1);
            #1;
            if (hold_blk && (!blk_valid_o || blk_data_o !== prev_blk)) stable_err++;
            if (hold_out && (!out_valid_o || out_data_o !== prev_out)) stable_err++;
            inf  = in_valid_i && in_ready_o;
            blkf = blk_valid_o && blk_ready_i && enable;
            resf = res_valid_i && res_ready_o;
            outf = out_valid_o && out_ready_i && enable;
            if (in_ready_o) in_ready_seen++;
            if (!enable && inf) frozen_fires++;
            if (inf) begin
                if (first_acc < 0) first_acc = t;
                in_idx++;
            end
            if (blkf) begin
                blk_seen.push_back(blk_data_o);
                stall = 0;
            end else if (blk_valid_o) begin
                stall++;
            end
            if (resf) res_idx++;
            if (outf) out_seen.push_back(out_data_o);
            hold_blk = blk_valid_o && !blkf;
            prev_blk = blk_data_o;
            hold_out = out_valid_o && !outf;
            prev_out = out_data_o;
            if (blk_cnt_o !== last_cnt) begin
                if (blk_cnt_o != '0) cnt_steps.push_back(blk_cnt_o);
                last_cnt = blk_cnt_o;
            end
            if (done_o) begin
                done_cnt++;
                if (done_t < 0) begin done_t = t; cnt_at_done = blk_cnt_o; end
            end
            if (done_cnt > 0) post++;
            if (post >= 3) fin = 1;
            if (clear_blk > 0 && out_valid_o && blk_seen.size() == clear_blk &&
                out_seen.size() >= 4*(clear_blk-1) + 1) begin
                clear = 1'b1;
                fin   = 1;
            end
            t++;
            if (!fin && t > 400) begin
                checks++; errors++;
                $display("FAIL job_timeout: got no done_o after %0d cycles, required done within 400", t);
                fin = 1;
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        enable    = 1'b1;
        nblocks_i = 16'd2;
        reset     = 1'b1;
        start     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (busy_o !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b required 0", busy_o); end
        checks++; if (done_o !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b required 0", done_o); end
        checks++; if (in_ready_o !== 1'b0)   begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready_o); end
        checks++; if (blk_valid_o !== 1'b0)  begin errors++; $display("FAIL reset_blk_valid: got %b required 0", blk_valid_o); end
        checks++; if (res_ready_o !== 1'b0)  begin errors++; $display("FAIL reset_res_ready: got %b required 0", res_ready_o); end
        checks++; if (out_valid_o !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid_o); end
        checks++; if (blk_cnt_o !== '0)      begin errors++; $display("FAIL reset_blk_cnt: got %h required 0", blk_cnt_o); end
        checks++; if (blk_data_o !== '0)     begin errors++; $display("FAIL reset_blk_data: got %h required 0", blk_data_o); end
        checks++; if (out_data_o !== '0)     begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data_o); end
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (busy_o !== 1'b0)       begin errors++; $display("FAIL post_reset_idle: got busy %b required 0", busy_o); end
    endtask

    task automatic test_single_block();
        run_job(1, 0, 0, 0, 0, 0, 0);
        checks++; if (blk_seen.size() != 1)  begin errors++; $display("FAIL single_blk_count: got %0d required 1", blk_seen.size()); end
        if (blk_seen.size() == 1) begin
            checks++; if (blk_seen[0] !== 128'h00112233445566778899AABBCCDDEEFF)
                begin errors++; $display("FAIL single_blk_data: got %h required 00112233445566778899aabbccddeeff", blk_seen[0]); end
        end
        checks++; if (out_seen.size() != 4)  begin errors++; $display("FAIL single_out_count: got %0d required 4", out_seen.size()); end
        if (out_seen.size() == 4) begin
            checks++; if (out_seen[0] !== 32'h69C4E0D8) begin errors++; $display("FAIL single_out0: got %h required 69c4e0d8", out_seen[0]); end
            checks++; if (out_seen[1] !== 32'h6A7B0430) begin errors++; $display("FAIL single_out1: got %h required 6a7b0430", out_seen[1]); end
            checks++; if (out_seen[2] !== 32'hD8CDB780) begin errors++; $display("FAIL single_out2: got %h required d8cdb780", out_seen[2]); end
            checks++; if (out_seen[3] !== 32'h70B4C55A) begin errors++; $display("FAIL single_out3: got %h required 70b4c55a", out_seen[3]); end
        end
        checks++; if (done_t - first_acc != 10) begin errors++; $display("FAIL single_latency: got %0d required 10", done_t - first_acc); end
        checks++; if (done_cnt != 1)         begin errors++; $display("FAIL single_done_pulses: got %0d required 1", done_cnt); end
        checks++; if (cnt_at_done !== 16'd1) begin errors++; $display("FAIL single_cnt_at_done: got %0d required 1", cnt_at_done); end
        checks++; if (blk_cnt_o !== 16'd1)   begin errors++; $display("FAIL single_cnt_hold: got %0d required 1", blk_cnt_o); end
        checks++; if (busy_o !== 1'b0)       begin errors++; $display("FAIL single_back_idle: got busy %b required 0", busy_o); end
    endtask

    task automatic test_back_pressure();
        run_job(1, 0, 3, 1, 0, 0, 0);
        checks++; if (stable_err != 0)       begin errors++; $display("FAIL bp_stability: got %0d unstable cycles required 0", stable_err); end
        checks++; if (blk_seen.size() != 1)  begin errors++; $display("FAIL bp_blk_count: got %0d required 1", blk_seen.size()); end
        if (blk_seen.size() == 1) begin
            checks++; if (blk_seen[0] !== exp_blk(0)) begin errors++; $display("FAIL bp_blk_data: got %h required %h", blk_seen[0], exp_blk(0)); end
        end
        checks++; if (out_seen.size() != 4)  begin errors++; $display("FAIL bp_out_count: got %0d required 4", out_seen.size()); end
        for (int j = 0; j < 4 && j < out_seen.size(); j++) begin
            checks++; if (out_seen[j] !== exp_word(j)) begin errors++; $display("FAIL bp_out%0d: got %h required %h", j, out_seen[j], exp_word(j)); end
        end
        checks++; if (done_cnt != 1)         begin errors++; $display("FAIL bp_done_pulses: got %0d required 1", done_cnt); end
    endtask

    task automatic test_zero_length();
        run_job(0, 0, 0, 0, 0, 0, 0);
        checks++; if (done_t != 0)           begin errors++; $display("FAIL zero_done_time: got cycle %0d required 0", done_t); end
        checks++; if (done_cnt != 1)         begin errors++; $display("FAIL zero_done_pulses: got %0d required 1", done_cnt); end
        checks++; if (in_ready_seen != 0)    begin errors++; $display("FAIL zero_in_ready: got %0d ready cycles required 0", in_ready_seen); end
        checks++; if (cnt_at_done !== '0)    begin errors++; $display("FAIL zero_blk_cnt: got %0d required 0", cnt_at_done); end
        checks++; if (blk_seen.size() != 0)  begin errors++; $display("FAIL zero_blocks: got %0d required 0", blk_seen.size()); end
    endtask

    task automatic test_enable_freeze();
        logic [BLOCK_W-1:0] b;
        run_job(1, 0, 0, 0, 1, 0, 0);
        checks++; if (frozen_fires != 0)     begin errors++; $display("FAIL freeze_accepts: got %0d required 0", frozen_fires); end
        checks++; if (blk_seen.size() != 1)  begin errors++; $display("FAIL freeze_blk_count: got %0d required 1", blk_seen.size()); end
        if (blk_seen.size() == 1) begin
            b = blk_seen[0];
            checks++; if (b[63:32] !== words[2]) begin errors++; $display("FAIL freeze_slot2: got %h required %h", b[63:32], words[2]); end
            checks++; if (b[31:0] !== words[3])  begin errors++; $display("FAIL freeze_slot3: got %h required %h", b[31:0], words[3]); end
            checks++; if (b !== exp_blk(0))      begin errors++; $display("FAIL freeze_blk_data: got %h required %h", b, exp_blk(0)); end
        end
        checks++; if (done_t - first_acc != 15) begin errors++; $display("FAIL freeze_latency: got %0d required 15", done_t - first_acc); end
    endtask

    task automatic test_clear_mid_job();
        run_job(3, 0, 0, 0, 0, 0, 2);
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (busy_o !== 1'b0)       begin errors++; $display("FAIL clear_busy: got %b required 0", busy_o); end
        checks++; if (out_valid_o !== 1'b0)  begin errors++; $display("FAIL clear_out_valid: got %b required 0", out_valid_o); end
        checks++; if (blk_valid_o !== 1'b0)  begin errors++; $display("FAIL clear_blk_valid: got %b required 0", blk_valid_o); end
        checks++; if (done_o !== 1'b0)       begin errors++; $display("FAIL clear_done: got %b required 0", done_o); end
        checks++; if (blk_cnt_o !== '0)      begin errors++; $display("FAIL clear_blk_cnt: got %0d required 0", blk_cnt_o); end
        checks++; if (blk_data_o !== '0)     begin errors++; $display("FAIL clear_blk_data: got %h required 0", blk_data_o); end
        checks++; if (out_data_o !== '0)     begin errors++; $display("FAIL clear_out_data: got %h required 0", out_data_o); end
        run_job(1, 0, 0, 0, 0, 0, 0);
        checks++; if (blk_seen.size() != 1 || blk_seen[0] !== exp_blk(0))
            begin errors++; $display("FAIL clear_restart_blk: got %0d blocks required 1 block %h", blk_seen.size(), exp_blk(0)); end
        checks++; if (out_seen.size() != 4 || out_seen[3] !== exp_word(3))
            begin errors++; $display("FAIL clear_restart_out: got %0d words required 4 ending %h", out_seen.size(), exp_word(3)); end
        checks++; if (done_cnt != 1 || cnt_at_done !== 16'd1)
            begin errors++; $display("FAIL clear_restart_done: got %0d pulses cnt %0d required 1 pulse cnt 1", done_cnt, cnt_at_done); end
    endtask

    task automatic test_multi_block();
        run_job(3, 1, 0, 0, 0, 1, 0);
        checks++; if (blk_seen.size() != 3)  begin errors++; $display("FAIL multi_blk_count: got %0d required 3", blk_seen.size()); end
        for (int b = 0; b < 3 && b < blk_seen.size(); b++) begin
            checks++; if (blk_seen[b] !== exp_blk(b)) begin errors++; $display("FAIL multi_blk%0d: got %h required %h", b, blk_seen[b], exp_blk(b)); end
        end
        checks++; if (out_seen.size() != 12) begin errors++; $display("FAIL multi_out_count: got %0d required 12", out_seen.size()); end
        for (int j = 0; j < 12 && j < out_seen.size(); j++) begin
            checks++; if (out_seen[j] !== exp_word(j)) begin errors++; $display("FAIL multi_out%0d: got %h required %h", j, out_seen[j], exp_word(j)); end
        end
        checks++; if (cnt_steps.size() != 3) begin errors++; $display("FAIL multi_cnt_steps: got %0d steps required 3", cnt_steps.size()); end
        for (int k = 0; k < 3 && k < cnt_steps.size(); k++) begin
            checks++; if (cnt_steps[k] !== CNT_W'(k+1)) begin errors++; $display("FAIL multi_cnt_step%0d: got %0d required %0d", k, cnt_steps[k], k+1); end
        end
        checks++; if (done_cnt != 1)         begin errors++; $display("FAIL multi_done_pulses: got %0d required 1", done_cnt); end
        checks++; if (cnt_at_done !== 16'd3) begin errors++; $display("FAIL multi_cnt_at_done: got %0d required 3", cnt_at_done); end
        checks++; if (stable_err != 0)       begin errors++; $display("FAIL multi_stability: got %0d unstable cycles required 0", stable_err); end
    endtask

    initial begin
        words[0]  = 32'h00112233; words[1]  = 32'h44556677;
        words[2]  = 32'h8899AABB; words[3]  = 32'hCCDDEEFF;
        words[4]  = 32'h01234567; words[5]  = 32'h89ABCDEF;
        words[6]  = 32'hFEDCBA98; words[7]  = 32'h76543210;
        words[8]  = 32'hDEADBEEF; words[9]  = 32'hCAFEF00D;
        words[10] = 32'h0BADC0DE; words[11] = 32'h13579BDF;
        results[0] = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
        results[1] = 128'h3925841D02DC09FBDC118597196A0B32;
        results[2] = 128'hA1B2C3D4E5F60718293A4B5C6D7E8F90;

        test_reset();
        test_single_block();
        test_back_pressure();
        test_zero_length();
        test_enable_freeze();
        test_clear_mid_job();
        test_multi_block();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
